// File: rtl/dram_wr_arbiter.sv
// rtl/dram_wr_arbiter.sv - round-robin N-channel DRAM write-burst arbiter with trigger freeze
module dram_wr_arbiter #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 25,
  parameter int BURST_LEN   = 16,
  parameter int BC_W        = 5,
  parameter int POST_BURSTS = 64,
  parameter int TS_W        = 16
) (
  input  logic                                       avalon_clk,
  input  logic                                       rst_n,
  input  logic [NUM_CH-1:0]                          buf_ready,
  input  logic [NUM_CH*DATA_W-1:0]                   buf_rd_data,
  output logic [NUM_CH-1:0]                          buf_rd_ack,
  input  logic                                       avl_waitrequest_n,
  output logic                                       avl_write,
  output logic                                       avl_beginbursttransfer,
  output logic [BC_W-1:0]                            avl_burstcount,
  output logic [ADDR_W-1:0]                          avl_address,
  output logic [DATA_W-1:0]                          avl_writedata,
  input  logic                                       trig_valid,
  input  logic [TS_W-1:0]                            trig_timestamp,
  input  logic                                       arm,
  output logic                                       frozen,
  output logic [TS_W-1:0]                            trig_ts_latched,
  output logic [NUM_CH*(ADDR_W-$clog2(NUM_CH))-1:0]  wr_ptr_flat,
  output logic [NUM_CH-1:0]                          wrapped
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int REG_W  = ADDR_W - CH_W;
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int PC_W   = $clog2(POST_BURSTS + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_FROZEN} state_t;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     grant;
  logic [CH_W-1:0]     rr_ptr;
  logic [CH_W-1:0]     pick;
  logic                pick_valid;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                first_beat;
  logic [ADDR_W-1:0]   addr_q;
  logic [REG_W-1:0]    wr_ptr [NUM_CH];
  logic [REG_W:0]      ptr_sum;
  logic [NUM_CH-1:0]   wrapped_q;
  logic                trig_pending;
  logic                burst_counts;
  logic [PC_W-1:0]     post_cnt;
  logic [TS_W-1:0]     ts_q;
  logic                beat_acc;
  logic                burst_end;
  logic                trig_acc;
  logic                do_grant;
  logic                window_done;

  // Circular search for the first ready channel at or after the round-robin pointer
  always_comb begin
    logic [CH_W-1:0] idx;
    idx        = '0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = rr_ptr + CH_W'(k);
      if (buf_ready[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  // Pointer advance for the granted channel; the extra top bit is the region carry
  assign ptr_sum = {1'b0, wr_ptr[grant]} + (REG_W + 1)'(BURST_LEN);

  // State register
  always_ff @(posedge avalon_clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic plus the per-cycle strobes that steer the datapath
  always_comb begin
    state_nxt   = state;
    do_grant    = 1'b0;
    burst_end   = 1'b0;
    beat_acc    = (state == S_BURST) && avl_waitrequest_n;
    trig_acc    = trig_valid && (state != S_FROZEN) && !trig_pending;
    window_done = burst_counts && ((post_cnt + PC_W'(1)) == PC_W'(POST_BURSTS));
    case (state)
      S_IDLE: begin
        // A zero-length window freezes as soon as the trigger is pending
        if (trig_pending && (post_cnt == PC_W'(POST_BURSTS))) begin
          state_nxt = S_FROZEN;
        end else if (pick_valid) begin
          do_grant  = 1'b1;
          state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (beat_acc && (beat_cnt == BEAT_W'(BURST_LEN - 1))) begin
          burst_end = 1'b1;
          state_nxt = window_done ? S_FROZEN : S_IDLE;
        end
      end
      S_FROZEN: begin
        if (arm) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant/burst bookkeeping, per-channel pointers and the trigger window
  always_ff @(posedge avalon_clk) begin
    if (!rst_n) begin
      grant        <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      first_beat   <= 1'b0;
      addr_q       <= '0;
      wrapped_q    <= '0;
      trig_pending <= 1'b0;
      burst_counts <= 1'b0;
      post_cnt     <= '0;
      ts_q         <= '0;
      for (int i = 0; i < NUM_CH; i++) wr_ptr[i] <= '0;
    end else begin
      if (do_grant) begin
        grant        <= pick;
        addr_q       <= {pick, wr_ptr[pick]};
        beat_cnt     <= '0;
        first_beat   <= 1'b1;
        // A burst granted in the trigger's own cycle still starts after it
        burst_counts <= trig_pending | trig_acc;
      end
      if (state == S_BURST) first_beat <= 1'b0;
      if (beat_acc) beat_cnt <= beat_cnt + BEAT_W'(1);
      if (burst_end) begin
        wr_ptr[grant] <= ptr_sum[REG_W-1:0];
        if (ptr_sum[REG_W]) wrapped_q[grant] <= 1'b1;
        rr_ptr <= grant + CH_W'(1);
        if (burst_counts) post_cnt <= post_cnt + PC_W'(1);
      end
      // Placed after the burst-end update so a same-cycle trigger restarts the count
      if (trig_acc) begin
        ts_q         <= trig_timestamp;
        trig_pending <= 1'b1;
        post_cnt     <= '0;
      end
      if ((state == S_FROZEN) && arm) begin
        trig_pending <= 1'b0;
        wrapped_q    <= '0;
      end
    end
  end

  assign avl_write              = (state == S_BURST);
  assign avl_beginbursttransfer = avl_write && first_beat;
  assign avl_burstcount         = BC_W'(BURST_LEN);
  assign avl_address            = addr_q;
  assign avl_writedata          = avl_write ? buf_rd_data[grant*DATA_W +: DATA_W] : '0;
  assign buf_rd_ack             = beat_acc ? (NUM_CH'(1) << grant) : '0;
  assign frozen                 = (state == S_FROZEN);
  assign trig_ts_latched        = ts_q;
  assign wrapped                = wrapped_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ptr
    assign wr_ptr_flat[c*REG_W +: REG_W] = wr_ptr[c];
  end

endmodule

// File: tb/tb_dram_wr_arbiter.sv
// tb/tb_dram_wr_arbiter.sv - directed self-checking bench for dram_wr_arbiter
module tb_dram_wr_arbiter;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int BURST_LEN = 16;
  localparam int BC_W = 5;
  localparam int POST_BURSTS = 4;
  localparam int TS_W = 16;
  localparam int REG_W = ADDR_W - 3;

  logic                      avalon_clk;
  logic                      rst_n;
  logic [NUM_CH-1:0]         buf_ready;
  logic [NUM_CH*DATA_W-1:0]  buf_rd_data;
  logic [NUM_CH-1:0]         buf_rd_ack;
  logic                      avl_waitrequest_n;
  logic                      avl_write;
  logic                      avl_beginbursttransfer;
  logic [BC_W-1:0]           avl_burstcount;
  logic [ADDR_W-1:0]         avl_address;
  logic [DATA_W-1:0]         avl_writedata;
  logic                      trig_valid;
  logic [TS_W-1:0]           trig_timestamp;
  logic                      arm;
  logic                      frozen;
  logic [TS_W-1:0]           trig_ts_latched;
  logic [NUM_CH*REG_W-1:0]   wr_ptr_flat;
  logic [NUM_CH-1:0]         wrapped;

  int errors = 0;
  int checks = 0;
  int unsigned pop_cnt [NUM_CH];

  dram_wr_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
    .BC_W(BC_W), .POST_BURSTS(POST_BURSTS), .TS_W(TS_W)
  ) dut (
    .avalon_clk(avalon_clk), .rst_n(rst_n), .buf_ready(buf_ready), .buf_rd_data(buf_rd_data),
    .buf_rd_ack(buf_rd_ack), .avl_waitrequest_n(avl_waitrequest_n), .avl_write(avl_write),
    .avl_beginbursttransfer(avl_beginbursttransfer), .avl_burstcount(avl_burstcount),
    .avl_address(avl_address), .avl_writedata(avl_writedata), .trig_valid(trig_valid),
    .trig_timestamp(trig_timestamp), .arm(arm), .frozen(frozen),
    .trig_ts_latched(trig_ts_latched), .wr_ptr_flat(wr_ptr_flat), .wrapped(wrapped)
  );

  initial avalon_clk = 1'b0;
  always #5 avalon_clk = ~avalon_clk;

  // Show-ahead buffer model: head word tags the channel in the top byte
  initial for (int c = 0; c < NUM_CH; c++) pop_cnt[c] = 0;
  always @(posedge avalon_clk)
    for (int c = 0; c < NUM_CH; c++) if (buf_rd_ack[c]) pop_cnt[c] <= pop_cnt[c] + 1;
  always_comb begin
    buf_rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) buf_rd_data[c*DATA_W +: DATA_W] = {8'(c), 24'(pop_cnt[c])};
  end

  function automatic logic [REG_W-1:0] ptr_of(input int c);
    return wr_ptr_flat[c*REG_W +: REG_W];
  endfunction

  task automatic apply_reset();
    @(negedge avalon_clk);
    rst_n = 1'b0; buf_ready = '0; avl_waitrequest_n = 1'b1;
    trig_valid = 1'b0; trig_timestamp = '0; arm = 1'b0;
    repeat (2) @(negedge avalon_clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Follows one burst on the bus, optionally stalling on beats 0/5/15 and pulsing a trigger
  task automatic do_burst(input int ch, input int ptr, input bit stall, input logic [7:0] next_ready,
                          input int trig_cyc, input logic [15:0] tts, input int exp_cycles,
                          input int exp_idle);
    int cyc, beats, stall_left, stalled_for, idle;
    bit started, done, wrn;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic [NUM_CH-1:0] eack;
    ea = ADDR_W'((ch << REG_W) + ptr);
    cyc = 0; beats = 0; stall_left = 0; stalled_for = -1; idle = 0;
    started = 0; done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge avalon_clk);
      trig_valid = 1'b0;
      avl_waitrequest_n = 1'b1;
      #1;
      if (!avl_write) begin
        if (started) done = 1; else idle++;
      end else begin
        if (!started) begin started = 1; buf_ready = next_ready; end
        wrn = 1;
        if (stall && (beats == 0 || beats == 5 || beats == 15) && stalled_for != beats) begin
          stall_left = 3; stalled_for = beats;
        end
        if (stall_left > 0) begin wrn = 0; stall_left--; end
        avl_waitrequest_n = wrn;
        if (cyc == trig_cyc) begin trig_valid = 1'b1; trig_timestamp = tts; end
        #1;
        ed = {8'(ch), 24'(pop_cnt[ch])};
        eack = wrn ? (NUM_CH'(1) << ch) : '0;
        checks += 4;
        if (avl_address !== ea) begin errors++;
          $display("FAIL burst_addr ch%0d cyc%0d: got %0h expected %0h", ch, cyc, avl_address, ea); end
        if (avl_beginbursttransfer !== (cyc == 0)) begin errors++;
          $display("FAIL burst_begin ch%0d cyc%0d: got %0b expected %0b", ch, cyc, avl_beginbursttransfer, cyc == 0); end
        if (buf_rd_ack !== eack) begin errors++;
          $display("FAIL burst_ack ch%0d cyc%0d: got %0h expected %0h", ch, cyc, buf_rd_ack, eack); end
        if (avl_writedata !== ed) begin errors++;
          $display("FAIL burst_data ch%0d cyc%0d: got %0h expected %0h", ch, cyc, avl_writedata, ed); end
        if (wrn) beats++;
        cyc++;
      end
    end
    trig_valid = 1'b0;
    checks += 3;
    if (!done) begin errors++; $display("FAIL burst_timeout ch%0d: got started=%0b expected completed burst", ch, started); end
    if (beats != BURST_LEN) begin errors++; $display("FAIL burst_beats ch%0d: got %0d expected %0d", ch, beats, BURST_LEN); end
    if (cyc != exp_cycles) begin errors++; $display("FAIL burst_cycles ch%0d: got %0d expected %0d", ch, cyc, exp_cycles); end
    if (exp_idle >= 0) begin
      checks++;
      if (idle != exp_idle) begin errors++; $display("FAIL burst_gap ch%0d: got %0d extra idle expected %0d", ch, idle, exp_idle); end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 10;
    if (avl_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %0b expected 0", avl_write); end
    if (avl_beginbursttransfer !== 1'b0) begin errors++; $display("FAIL rst_begin: got %0b expected 0", avl_beginbursttransfer); end
    if (buf_rd_ack !== 8'h00) begin errors++; $display("FAIL rst_ack: got %0h expected 0", buf_rd_ack); end
    if (frozen !== 1'b0) begin errors++; $display("FAIL rst_frozen: got %0b expected 0", frozen); end
    if (trig_ts_latched !== 16'h0) begin errors++; $display("FAIL rst_ts: got %0h expected 0", trig_ts_latched); end
    if (wr_ptr_flat !== '0) begin errors++; $display("FAIL rst_ptr: got %0h expected 0", wr_ptr_flat); end
    if (wrapped !== 8'h00) begin errors++; $display("FAIL rst_wrapped: got %0h expected 0", wrapped); end
    if (avl_burstcount !== 5'd16) begin errors++; $display("FAIL rst_burstcount: got %0d expected 16", avl_burstcount); end
    if (avl_address !== '0) begin errors++; $display("FAIL rst_addr: got %0h expected 0", avl_address); end
    if (avl_writedata !== '0) begin errors++; $display("FAIL rst_data: got %0h expected 0", avl_writedata); end
  endtask

  task automatic test_single_channel();
    buf_ready = 8'h04;
    do_burst(2, 0, 0, 8'h00, -1, 16'h0, 16, -1);
    checks++;
    if (ptr_of(2) !== 7'd16) begin errors++; $display("FAIL single_ptr2: got %0d expected 16", ptr_of(2)); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    buf_ready = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      do_burst(k % 8, (k < 8) ? 0 : 16, 0, (k == 8) ? 8'h00 : 8'hFF, -1, 16'h0, 16, (k == 0) ? -1 : 0);
      if (k == 7) begin
        for (int c = 0; c < NUM_CH; c++) begin
          checks++;
          if (ptr_of(c) !== 7'd16) begin errors++; $display("FAIL rr_ptr%0d: got %0d expected 16", c, ptr_of(c)); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    buf_ready = 8'h02;
    do_burst(1, 16, 1, 8'h00, -1, 16'h0, 25, -1);
    checks++;
    if (ptr_of(1) !== 7'd32) begin errors++; $display("FAIL bp_ptr1: got %0d expected 32", ptr_of(1)); end
  endtask

  task automatic test_wrap();
    apply_reset();
    buf_ready = 8'h01;
    for (int k = 0; k < 8; k++) begin
      do_burst(0, 16 * k, 0, (k == 7) ? 8'h00 : 8'h01, -1, 16'h0, 16, (k == 0) ? -1 : 0);
      if (k == 6) begin
        checks++;
        if (wrapped !== 8'h00) begin errors++; $display("FAIL wrap_early: got %0h expected 0", wrapped); end
      end
    end
    checks += 2;
    if (ptr_of(0) !== 7'd0) begin errors++; $display("FAIL wrap_ptr0: got %0d expected 0", ptr_of(0)); end
    if (wrapped !== 8'h01) begin errors++; $display("FAIL wrap_flag: got %0h expected 01", wrapped); end
  endtask

  task automatic test_trigger_window();
    bit seen_write;
    buf_ready = 8'h08;
    for (int j = 0; j < 5; j++) begin
      do_burst(3, 16 * j, 0, 8'h08, (j == 0) ? 4 : ((j == 1) ? 3 : -1),
               (j == 0) ? 16'h1234 : 16'h5678, 16, (j == 0) ? -1 : 0);
      checks++;
      if (frozen !== (j == 4)) begin errors++; $display("FAIL trig_frozen_b%0d: got %0b expected %0b", j, frozen, j == 4); end
    end
    seen_write = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge avalon_clk);
      trig_valid = (t == 2); trig_timestamp = 16'h9999;
      #1;
      if (avl_write) seen_write = 1;
    end
    @(negedge avalon_clk);
    trig_valid = 1'b0;
    #1;
    checks += 4;
    if (seen_write !== 1'b0) begin errors++; $display("FAIL frozen_write: got write expected none"); end
    if (trig_ts_latched !== 16'h1234) begin errors++; $display("FAIL trig_ts: got %0h expected 1234", trig_ts_latched); end
    if (ptr_of(3) !== 7'd80) begin errors++; $display("FAIL frozen_ptr3: got %0d expected 80", ptr_of(3)); end
    if (wrapped !== 8'h01) begin errors++; $display("FAIL frozen_wrapped: got %0h expected 01", wrapped); end
    @(negedge avalon_clk);
    arm = 1'b1; trig_valid = 1'b1; trig_timestamp = 16'hAAAA;
    @(negedge avalon_clk);
    arm = 1'b0; trig_valid = 1'b0;
    #1;
    checks += 2;
    if (frozen !== 1'b0) begin errors++; $display("FAIL arm_frozen: got %0b expected 0", frozen); end
    if (wrapped !== 8'h00) begin errors++; $display("FAIL arm_wrapped: got %0h expected 0", wrapped); end
    do_burst(3, 80, 0, 8'h00, -1, 16'h0, 16, -1);
    checks++;
    if (trig_ts_latched !== 16'h1234) begin errors++; $display("FAIL arm_trig_dropped: got %0h expected 1234", trig_ts_latched); end
  endtask

  task automatic test_reset_mid_burst();
    int beats;
    bit started;
    buf_ready = 8'h24;
    started = 0; beats = 0;
    for (int t = 0; t < 60 && !(started && beats == 7); t++) begin
      @(negedge avalon_clk);
      #1;
      if (avl_write) begin
        if (started) beats++;
        started = 1;
      end
    end
    checks += 2;
    if (!(started && beats == 7)) begin errors++; $display("FAIL rmid_timeout: got beats=%0d expected 7", beats); end
    if (avl_address !== 10'h280) begin errors++; $display("FAIL rmid_pre_addr: got %0h expected 280", avl_address); end
    rst_n = 1'b0;
    @(negedge avalon_clk);
    #1;
    checks += 8;
    if (avl_write !== 1'b0) begin errors++; $display("FAIL rmid_write: got %0b expected 0", avl_write); end
    if (avl_beginbursttransfer !== 1'b0) begin errors++; $display("FAIL rmid_begin: got %0b expected 0", avl_beginbursttransfer); end
    if (buf_rd_ack !== 8'h00) begin errors++; $display("FAIL rmid_ack: got %0h expected 0", buf_rd_ack); end
    if (avl_address !== '0) begin errors++; $display("FAIL rmid_addr: got %0h expected 0", avl_address); end
    if (avl_writedata !== '0) begin errors++; $display("FAIL rmid_data: got %0h expected 0", avl_writedata); end
    if (wr_ptr_flat !== '0) begin errors++; $display("FAIL rmid_ptr: got %0h expected 0", wr_ptr_flat); end
    if (trig_ts_latched !== 16'h0) begin errors++; $display("FAIL rmid_ts: got %0h expected 0", trig_ts_latched); end
    if (frozen !== 1'b0 || wrapped !== 8'h00) begin errors++;
      $display("FAIL rmid_status: got frozen=%0b wrapped=%0h expected 0/0", frozen, wrapped); end
    rst_n = 1'b1;
    do_burst(2, 0, 0, 8'h00, -1, 16'h0, 16, -1);
  endtask

  initial begin
    rst_n = 1'b0; buf_ready = '0; avl_waitrequest_n = 1'b1;
    trig_valid = 1'b0; trig_timestamp = '0; arm = 1'b0;
    test_reset();
    test_single_channel();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_trigger_window();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_wr_arbiter.md
Name: dram_wr_arbiter

Overview:
- Parametrised N-channel replacement for the fixed 2-way buffer-select mux and single-channel DRAM address generator.
- Round-robin arbitrates among NUM_CH channel reorder buffers and moves one BURST_LEN-beat Avalon-MM write burst at a time into DRAM.
- Each channel owns a circular DRAM region.
- A trigger starts a post-trigger window of POST_BURSTS bursts. When the window ends, writing freezes and per-channel write pointers are published for readout.

Parameters:
- NUM_CH, 8, number of reorder-buffer channels (power of 2, 2..16).
- DATA_W, 256, DRAM/buffer word width.
- ADDR_W, 25, Avalon word address width.
- BURST_LEN, 16, beats per burst (power of 2, ≤ 2^(BC_W-1)).
- BC_W, 5, burstcount width.
- POST_BURSTS, 64, bursts written after trigger before freeze (0 allowed).
- TS_W, 16, trigger timestamp width.

Ports:
- avalon_clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- buf_ready  in  NUM_CH  bit i=1: channel i holds ≥BURST_LEN words.
- buf_rd_data  in  NUM_CH*DATA_W  show-ahead head word per channel, channel i at [i*DATA_W +: DATA_W].
- buf_rd_ack  out  NUM_CH  one-hot pop, one cycle per accepted beat.
- avl_waitrequest_n  in  1  DRAM ready.
- avl_write  out  1  write request.
- avl_beginbursttransfer  out  1  first-cycle burst marker.
- avl_burstcount  out  BC_W  burst length.
- avl_address  out  ADDR_W  burst start address.
- avl_writedata  out  DATA_W  write data.
- trig_valid  in  1  one-cycle trigger pulse (avalon_clk domain).
- trig_timestamp  in  TS_W  timestamp, valid with trig_valid.
- arm  in  1  one-cycle pulse: leave FROZEN, resume capture.
- frozen  out  1  capture stopped.
- trig_ts_latched  out  TS_W  timestamp of accepted trigger.
- wr_ptr_flat  out  NUM_CH*(ADDR_W-log2(NUM_CH))  per-channel next write offset in region.
- wrapped  out  NUM_CH  channel region wrapped at least once since reset/arm.

Behaviour:
- Reset (rst_n=0 at a clock edge) values:
  - Outputs: avl_write=0, avl_beginbursttransfer=0, buf_rd_ack=0, frozen=0, trig_ts_latched=0, wr_ptr_flat=0, wrapped=0.
  - avl_burstcount=BURST_LEN (constant). avl_address=0, avl_writedata=0.
  - Internal: RR pointer=0, post-trigger counter=0, state=IDLE, trigger-pending=0.
  - A reset during a burst aborts it. avl_write is low the cycle after the reset edge, and partial data is abandoned.
- Address map:
  - Channel c region base = c << (ADDR_W-log2(NUM_CH)).
  - avl_address = base_c + wr_ptr_c.
  - wr_ptr_c advances by BURST_LEN at burst end, modulo region size.
  - A carry out of the region sets wrapped[c] (sticky).
- State IDLE:
  - If any buf_ready bit is set, grant the first ready channel at or after RR pointer (circular search). Register grant, address and first data; go to BURST next cycle.
  - If none are ready, stay in IDLE.
  - Arbitration takes 1 cycle, so there is 1 idle cycle between bursts.
- State BURST:
  - avl_write=1 throughout. avl_beginbursttransfer=1 only on the first cycle of the burst, whether or not waitrequest_n is high.
  - avl_address is held for the whole burst.
  - avl_writedata = granted channel's head word (mux on registered grant).
  - A beat is accepted when avl_write & avl_waitrequest_n. On acceptance, pulse buf_rd_ack[grant] the same cycle and increment the beat counter.
  - While waitrequest_n=0, all outputs are held and no ack is issued.
  - After BURST_LEN accepted beats:
    - deassert avl_write next cycle;
    - update wr_ptr/wrapped;
    - RR pointer = grant+1 (mod NUM_CH);
    - go to IDLE.
  - buf_ready is not re-checked mid-burst. The upstream buffer guarantees BURST_LEN words.
- Trigger:
  - Accepted only when frozen=0 and no trigger is pending; otherwise ignored.
  - On acceptance, latch trig_timestamp into trig_ts_latched, set trigger-pending and clear the post counter.
  - An in-progress burst completes and does not count toward the window.
  - Each burst that starts after acceptance increments the post counter when it completes.
  - When counter = POST_BURSTS at a burst end, or immediately in IDLE when POST_BURSTS=0, go to FROZEN with frozen=1.
- State FROZEN:
  - No grants, no writes. wr_ptr_flat, wrapped and trig_ts_latched are stable.
  - arm=1: clear frozen, trigger-pending and wrapped; go to IDLE. wr_ptr values are kept.
  - arm outside FROZEN is ignored.
  - trig_valid and arm in the same cycle while FROZEN: arm wins, the trigger is dropped.

Test Plan:
- Single channel (NUM_CH=8, BURST_LEN=16):
  - Stimulus: buf_ready=8'h04, waitrequest_n=1.
  - Response: exactly 16 beats; avl_address=0x0800000 (c=2, ADDR_W=25); begin on beat 0 only; 16 acks on bit 2; wr_ptr[2]=16.
- Round-robin fairness:
  - Stimulus: buf_ready=8'hFF held.
  - Response: grants 0,1,…,7,0; one idle cycle between bursts; every channel wr_ptr=16 after 8 bursts.
- Backpressure:
  - Stimulus: waitrequest_n low on beats 0, 5 and 15 for 3 cycles each.
  - Response: data/address held; no ack while low; exactly 16 acks; burst lasts 25 cycles.
- Wrap-around:
  - Stimulus: preload a small region (NUM_CH=8, ADDR_W=10 → 128-word region) and write 8 bursts to channel 0.
  - Response: addresses 0,16,…,112; wr_ptr[0]=0; wrapped[0]=1.
- Trigger window (POST_BURSTS=4):
  - Stimulus: trig_valid with ts=0x1234 mid-burst; second trig during window.
  - Response: current burst plus 4 more bursts, then frozen=1; trig_ts_latched=0x1234; second trig ignored.
  - Then: arm clears frozen and wrapped, and writing resumes from the held pointers.
- Reset mid-burst:
  - Stimulus: rst_n=0 at beat 7.
  - Response: next cycle avl_write=0; all outputs at reset values; after release, the first grant goes to the lowest ready channel.
